// File: rtl/can_field_sequencer.sv
// can_field_sequencer
// Follows the position of every de-stuffed bit of a CAN 2.0A/B frame. All
// outputs are registered and describe the next bit to be sampled, so the
// delimiter/EOF flags are stable when the form checker samples them on SP.
// The decoded frame header (IDE, RTR, DLC) is exported for the rest of the
// controller.

module can_field_sequencer #(
    parameter int MAX_BYTES = 8,   // data bytes used when DLC > 8 (1..8)
    parameter int EOF_LEN   = 7,   // EOF bits
    parameter int IFS_LEN   = 3,   // intermission bits
    parameter int IDLE_LEN  = 11   // recessive bits that end error recovery
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SP,
    input  logic       RX,
    input  logic       STUFF,
    input  logic       ERR,
    output logic       F_CRC_D,
    output logic       F_ACK_D,
    output logic       F_EOF,
    output logic [3:0] FIELD,
    output logic [5:0] BIT_CNT,
    output logic       IDE,
    output logic       RTR,
    output logic [3:0] DLC,
    output logic       CRC_EN,
    output logic       FRAME_DONE
);

    typedef enum logic [3:0] {
        FLD_IDLE     = 4'd0,
        FLD_ID_A     = 4'd1,
        FLD_SRR_RTR  = 4'd2,
        FLD_IDE      = 4'd3,
        FLD_ID_B     = 4'd4,
        FLD_RTR_B    = 4'd5,
        FLD_RES      = 4'd6,
        FLD_DLC      = 4'd7,
        FLD_DATA     = 4'd8,
        FLD_CRC      = 4'd9,
        FLD_CRC_DEL  = 4'd10,
        FLD_ACK_SLOT = 4'd11,
        FLD_ACK_DEL  = 4'd12,
        FLD_EOF      = 4'd13,
        FLD_IFS      = 4'd14,
        FLD_ERROR    = 4'd15
    } field_t;

    // Last BIT_CNT value of each fixed-length field
    localparam logic [5:0] ID_A_LAST  = 6'd10;
    localparam logic [5:0] ID_B_LAST  = 6'd17;
    localparam logic [5:0] DLC_LAST   = 6'd3;
    localparam logic [5:0] CRC_LAST   = 6'd14;
    localparam logic [5:0] EOF_LAST   = 6'(EOF_LEN - 1);
    localparam logic [5:0] IFS_LAST   = 6'(IFS_LEN - 1);
    localparam logic [5:0] IDLE_LAST  = 6'(IDLE_LEN - 1);
    localparam logic [3:0] BYTES_CAP  = 4'(MAX_BYTES);

    field_t     field;
    field_t     field_nxt;
    logic [5:0] cnt_nxt;
    logic [5:0] cnt_inc;
    logic       ide_nxt;
    logic       rtr_nxt;
    logic [3:0] dlc_nxt;
    logic       srr;
    logic       srr_nxt;
    logic [5:0] data_last;
    logic [5:0] data_last_nxt;
    logic       crc_en_nxt;
    logic       done_nxt;
    logic [3:0] dlc_full;
    logic [3:0] nbytes;
    logic [6:0] data_bits;
    logic       stuff_zone;
    logic       take_bit;

    assign FIELD = field;

    // Saturating increment; the counter never wraps back to a valid index
    assign cnt_inc = (BIT_CNT == 6'd63) ? 6'd63 : BIT_CNT + 6'd1;

    // Stuff bits only exist from SOF through the CRC sequence
    assign stuff_zone = (field >= FLD_ID_A) && (field <= FLD_CRC);
    assign take_bit   = SP && !(STUFF && stuff_zone);

    // Next-state decode for field position, header latches and CRC enable
    always_comb begin
        field_nxt     = field;
        cnt_nxt       = BIT_CNT;
        ide_nxt       = IDE;
        rtr_nxt       = RTR;
        dlc_nxt       = DLC;
        srr_nxt       = srr;
        data_last_nxt = data_last;
        crc_en_nxt    = CRC_EN;
        done_nxt      = 1'b0;
        dlc_full      = {DLC[2:0], RX};
        nbytes        = (dlc_full > BYTES_CAP) ? BYTES_CAP : dlc_full;
        data_bits     = {nbytes, 3'b000};

        if (ERR && (field != FLD_IDLE)) begin
            field_nxt  = FLD_ERROR;
            cnt_nxt    = 6'd0;
            crc_en_nxt = 1'b0;
        end else if (take_bit) begin
            cnt_nxt = cnt_inc;
            case (field)
                FLD_IDLE: begin
                    cnt_nxt = 6'd0;
                    if (!RX) begin
                        field_nxt  = FLD_ID_A;
                        crc_en_nxt = 1'b1;
                        ide_nxt    = 1'b0;
                        rtr_nxt    = 1'b0;
                        dlc_nxt    = 4'd0;
                    end
                end
                FLD_ID_A: begin
                    if (BIT_CNT == ID_A_LAST) field_nxt = FLD_SRR_RTR;
                end
                FLD_SRR_RTR: begin
                    // Only becomes RTR once IDE shows this is a standard frame
                    srr_nxt   = RX;
                    field_nxt = FLD_IDE;
                end
                FLD_IDE: begin
                    ide_nxt = RX;
                    if (RX) begin
                        field_nxt = FLD_ID_B;
                    end else begin
                        rtr_nxt   = srr;
                        field_nxt = FLD_RES;
                    end
                end
                FLD_ID_B: begin
                    if (BIT_CNT == ID_B_LAST) field_nxt = FLD_RTR_B;
                end
                FLD_RTR_B: begin
                    rtr_nxt   = RX;
                    field_nxt = FLD_RES;
                end
                FLD_RES: begin
                    // Extended frames carry r1 and r0, standard frames only r0
                    if (!IDE || (BIT_CNT == 6'd1)) field_nxt = FLD_DLC;
                end
                FLD_DLC: begin
                    dlc_nxt = dlc_full;
                    if (BIT_CNT == DLC_LAST) begin
                        if (RTR || (nbytes == 4'd0)) begin
                            field_nxt  = FLD_CRC;
                            crc_en_nxt = 1'b0;
                        end else begin
                            field_nxt     = FLD_DATA;
                            data_last_nxt = 6'(data_bits - 7'd1);
                        end
                    end
                end
                FLD_DATA: begin
                    if (BIT_CNT == data_last) begin
                        field_nxt  = FLD_CRC;
                        crc_en_nxt = 1'b0;
                    end
                end
                FLD_CRC: begin
                    if (BIT_CNT == CRC_LAST) field_nxt = FLD_CRC_DEL;
                end
                FLD_CRC_DEL: begin
                    field_nxt = FLD_ACK_SLOT;
                end
                FLD_ACK_SLOT: begin
                    field_nxt = FLD_ACK_DEL;
                end
                FLD_ACK_DEL: begin
                    field_nxt = FLD_EOF;
                end
                FLD_EOF: begin
                    if (BIT_CNT == EOF_LAST) begin
                        field_nxt = FLD_IFS;
                        done_nxt  = 1'b1;
                    end
                end
                FLD_IFS: begin
                    if (BIT_CNT == IFS_LAST) field_nxt = FLD_IDLE;
                end
                FLD_ERROR: begin
                    // Recovery needs an unbroken run of recessive samples
                    if (RX) begin
                        if (BIT_CNT == IDLE_LAST) field_nxt = FLD_IDLE;
                    end else begin
                        cnt_nxt = 6'd0;
                    end
                end
            endcase
            if (field_nxt != field) cnt_nxt = 6'd0;
        end
    end

    // Registered state and outputs; flags decode the field of the next bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field      <= FLD_IDLE;
            BIT_CNT    <= 6'd0;
            IDE        <= 1'b0;
            RTR        <= 1'b0;
            DLC        <= 4'd0;
            srr        <= 1'b0;
            data_last  <= 6'd0;
            CRC_EN     <= 1'b0;
            FRAME_DONE <= 1'b0;
            F_CRC_D    <= 1'b1;
            F_ACK_D    <= 1'b1;
            F_EOF      <= 1'b1;
        end else begin
            field      <= field_nxt;
            BIT_CNT    <= cnt_nxt;
            IDE        <= ide_nxt;
            RTR        <= rtr_nxt;
            DLC        <= dlc_nxt;
            srr        <= srr_nxt;
            data_last  <= data_last_nxt;
            CRC_EN     <= crc_en_nxt;
            FRAME_DONE <= done_nxt;
            F_CRC_D    <= (field_nxt != FLD_CRC_DEL);
            F_ACK_D    <= (field_nxt != FLD_ACK_DEL);
            F_EOF      <= (field_nxt != FLD_EOF);
        end
    end

endmodule

// File: tb/tb_can_field_sequencer.sv
// tb_can_field_sequencer
// Directed frames for the CAN field sequencer. Bits are indexed from SOF = 0
// with stuff bits excluded; expected flag positions come from the frame layout
// of each directed case.

module tb_can_field_sequencer;

    localparam logic [7:0] FLD_IDLE     = 8'd0;
    localparam logic [7:0] FLD_ID_A     = 8'd1;
    localparam logic [7:0] FLD_ID_B     = 8'd4;
    localparam logic [7:0] FLD_RTR_B    = 8'd5;
    localparam logic [7:0] FLD_RES      = 8'd6;
    localparam logic [7:0] FLD_DLC      = 8'd7;
    localparam logic [7:0] FLD_DATA     = 8'd8;
    localparam logic [7:0] FLD_CRC      = 8'd9;
    localparam logic [7:0] FLD_ACK_SLOT = 8'd11;
    localparam logic [7:0] FLD_IFS      = 8'd14;
    localparam logic [7:0] FLD_ERROR    = 8'd15;

    logic       clk;
    logic       reset;
    logic       SP;
    logic       RX;
    logic       STUFF;
    logic       ERR;
    logic       F_CRC_D;
    logic       F_ACK_D;
    logic       F_EOF;
    logic [3:0] FIELD;
    logic [5:0] BIT_CNT;
    logic       IDE;
    logic       RTR;
    logic [3:0] DLC;
    logic       CRC_EN;
    logic       FRAME_DONE;

    int   checkCount = 0;
    int   passCount  = 0;
    logic frameBits[$];
    int   pos;
    int   crcDel;
    int   lastCrc;
    bit   stuffAtCrcDel;

    can_field_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .SP        (SP),
        .RX        (RX),
        .STUFF     (STUFF),
        .ERR       (ERR),
        .F_CRC_D   (F_CRC_D),
        .F_ACK_D   (F_ACK_D),
        .F_EOF     (F_EOF),
        .FIELD     (FIELD),
        .BIT_CNT   (BIT_CNT),
        .IDE       (IDE),
        .RTR       (RTR),
        .DLC       (DLC),
        .CRC_EN    (CRC_EN),
        .FRAME_DONE(FRAME_DONE)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_F_CRC_D"}, 8'(F_CRC_D), 8'd1);
        checkOutput({tag, "_F_ACK_D"}, 8'(F_ACK_D), 8'd1);
        checkOutput({tag, "_F_EOF"}, 8'(F_EOF), 8'd1);
        checkOutput({tag, "_FIELD"}, 8'(FIELD), FLD_IDLE);
        checkOutput({tag, "_BIT_CNT"}, 8'(BIT_CNT), 8'd0);
        checkOutput({tag, "_IDE"}, 8'(IDE), 8'd0);
        checkOutput({tag, "_RTR"}, 8'(RTR), 8'd0);
        checkOutput({tag, "_DLC"}, 8'(DLC), 8'd0);
        checkOutput({tag, "_CRC_EN"}, 8'(CRC_EN), 8'd0);
        checkOutput({tag, "_FRAME_DONE"}, 8'(FRAME_DONE), 8'd0);
    endtask

    // One sample point, preceded by an idle clock so outputs must hold between SPs
    task automatic applyStimulus(input logic rx, input logic stuff);
        @(negedge clk);
        @(negedge clk);
        SP    = 1'b1;
        RX    = rx;
        STUFF = stuff;
        @(posedge clk);
        #1;
        SP    = 1'b0;
        STUFF = 1'b0;
    endtask

    task automatic pulseErr();
        @(negedge clk);
        ERR = 1'b1;
        @(posedge clk);
        #1;
        ERR = 1'b0;
    endtask

    task automatic pushBits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frameBits.push_back(v[i]);
    endtask

    task automatic buildFrame(input bit ext, input logic [28:0] id, input logic rtr,
                              input logic [3:0] dlc, input int nData,
                              input logic [63:0] data);
        frameBits.delete();
        pos = 0;
        pushBits(64'd0, 1);
        if (ext) begin
            pushBits(64'(id[28:18]), 11);
            pushBits(64'd1, 1);
            pushBits(64'd1, 1);
            pushBits(64'(id[17:0]), 18);
            pushBits(64'(rtr), 1);
            pushBits(64'd0, 2);
        end else begin
            pushBits(64'(id[10:0]), 11);
            pushBits(64'(rtr), 1);
            pushBits(64'd0, 1);
            pushBits(64'd0, 1);
        end
        pushBits(64'(dlc), 4);
        if (nData > 0) pushBits(data, nData);
        pushBits(64'h4B2D, 15);
        pushBits(64'd1, 1);
        pushBits(64'd0, 1);
        pushBits(64'd1, 1);
        pushBits(64'h7F, 7);
        pushBits(64'h7, 3);
    endtask

    // Sends frame bits pos..last and checks the per-bit flags after each one
    task automatic runTo(input int last);
        for (int k = pos; k <= last; k++) begin
            applyStimulus(frameBits[k], stuffAtCrcDel && (k == crcDel));
            checkOutput($sformatf("F_CRC_D@%0d", k), 8'(F_CRC_D), 8'((k + 1) != crcDel));
            checkOutput($sformatf("F_ACK_D@%0d", k), 8'(F_ACK_D), 8'((k + 1) != crcDel + 2));
            checkOutput($sformatf("F_EOF@%0d", k), 8'(F_EOF),
                        8'(!(((k + 1) >= crcDel + 3) && ((k + 1) <= crcDel + 9))));
            checkOutput($sformatf("CRC_EN@%0d", k), 8'(CRC_EN), 8'(k < lastCrc));
            checkOutput($sformatf("FRAME_DONE@%0d", k), 8'(FRAME_DONE), 8'(k == crcDel + 9));
            if (k == crcDel + 9) begin
                @(posedge clk);
                #1;
                checkOutput("FRAME_DONE_width", 8'(FRAME_DONE), 8'd0);
            end
            if (k == crcDel + 11) checkOutput("FIELD_IFS", 8'(FIELD), FLD_IFS);
            if (k == crcDel + 12) checkOutput("FIELD_end_idle", 8'(FIELD), FLD_IDLE);
        end
        pos = last + 1;
    endtask

    // Directed sequence
    initial begin
        reset = 1'b0;
        SP    = 1'b0;
        RX    = 1'b1;
        STUFF = 1'b0;
        ERR   = 1'b0;
        stuffAtCrcDel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("por");
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] case 1: standard frame ID=0x123 DLC=1");
        applyStimulus(1'b1, 1'b0);
        checkOutput("idle_recessive", 8'(FIELD), FLD_IDLE);
        buildFrame(1'b0, 29'h123, 1'b0, 4'd1, 8, 64'hA5);
        crcDel = 42;
        lastCrc = 26;
        runTo(0);
        checkOutput("c1_sof_field", 8'(FIELD), FLD_ID_A);
        checkOutput("c1_sof_cnt", 8'(BIT_CNT), 8'd0);
        runTo(5);
        checkOutput("c1_ida_cnt", 8'(BIT_CNT), 8'd5);
        runTo(13);
        checkOutput("c1_res_field", 8'(FIELD), FLD_RES);
        runTo(18);
        checkOutput("c1_data_field", 8'(FIELD), FLD_DATA);
        checkOutput("c1_dlc", 8'(DLC), 8'd1);
        checkOutput("c1_ide", 8'(IDE), 8'd0);
        checkOutput("c1_rtr", 8'(RTR), 8'd0);
        runTo(26);
        checkOutput("c1_crc_field", 8'(FIELD), FLD_CRC);
        checkOutput("c1_crc_cnt", 8'(BIT_CNT), 8'd0);
        runTo(54);

        $display("[TB] case 2: standard RTR frame DLC=4");
        buildFrame(1'b0, 29'h2A5, 1'b1, 4'd4, 0, 64'd0);
        crcDel = 34;
        lastCrc = 18;
        runTo(13);
        checkOutput("c2_rtr", 8'(RTR), 8'd1);
        checkOutput("c2_res_field", 8'(FIELD), FLD_RES);
        runTo(17);
        checkOutput("c2_dlc_field", 8'(FIELD), FLD_DLC);
        checkOutput("c2_dlc_cnt", 8'(BIT_CNT), 8'd3);
        runTo(18);
        checkOutput("c2_crc_field", 8'(FIELD), FLD_CRC);
        checkOutput("c2_dlc", 8'(DLC), 8'd4);
        runTo(46);

        $display("[TB] case 3: standard frame DLC=15");
        buildFrame(1'b0, 29'h7F0, 1'b0, 4'd15, 64, 64'h0123456789ABCDEF);
        crcDel = 98;
        lastCrc = 82;
        runTo(13);
        checkOutput("c3_rtr", 8'(RTR), 8'd0);
        runTo(18);
        checkOutput("c3_data_field", 8'(FIELD), FLD_DATA);
        checkOutput("c3_dlc", 8'(DLC), 8'd15);
        runTo(81);
        checkOutput("c3_data_last_field", 8'(FIELD), FLD_DATA);
        checkOutput("c3_data_last_cnt", 8'(BIT_CNT), 8'd63);
        runTo(82);
        checkOutput("c3_crc_field", 8'(FIELD), FLD_CRC);
        runTo(110);

        $display("[TB] case 4: extended frame DLC=2");
        buildFrame(1'b1, 29'h1ABCDE12, 1'b0, 4'd2, 16, 64'hC35A);
        crcDel = 70;
        lastCrc = 54;
        runTo(13);
        checkOutput("c4_idb_field", 8'(FIELD), FLD_ID_B);
        checkOutput("c4_ide", 8'(IDE), 8'd1);
        runTo(31);
        checkOutput("c4_rtrb_field", 8'(FIELD), FLD_RTR_B);
        runTo(32);
        checkOutput("c4_res_field", 8'(FIELD), FLD_RES);
        checkOutput("c4_rtr", 8'(RTR), 8'd0);
        runTo(33);
        checkOutput("c4_res_cnt", 8'(BIT_CNT), 8'd1);
        runTo(34);
        checkOutput("c4_dlc_field", 8'(FIELD), FLD_DLC);
        runTo(38);
        checkOutput("c4_data_field", 8'(FIELD), FLD_DATA);
        checkOutput("c4_dlc", 8'(DLC), 8'd2);
        runTo(54);
        checkOutput("c4_crc_field", 8'(FIELD), FLD_CRC);
        runTo(82);

        $display("[TB] case 5: stuff bit in ID_A, STUFF at CRC delimiter");
        buildFrame(1'b0, 29'h123, 1'b0, 4'd1, 8, 64'hA5);
        crcDel = 42;
        lastCrc = 26;
        stuffAtCrcDel = 1'b1;
        runTo(5);
        applyStimulus(~frameBits[5], 1'b1);
        checkOutput("c5_stuff_field", 8'(FIELD), FLD_ID_A);
        checkOutput("c5_stuff_cnt", 8'(BIT_CNT), 8'd5);
        runTo(42);
        checkOutput("c5_crcdel_stuff_ignored", 8'(FIELD), FLD_ACK_SLOT);
        runTo(54);
        stuffAtCrcDel = 1'b0;

        $display("[TB] case 6: error in DATA and recovery");
        buildFrame(1'b0, 29'h123, 1'b0, 4'd1, 8, 64'hA5);
        runTo(22);
        checkOutput("c6_pre_err_field", 8'(FIELD), FLD_DATA);
        pulseErr();
        checkOutput("c6_err_field", 8'(FIELD), FLD_ERROR);
        checkOutput("c6_err_cnt", 8'(BIT_CNT), 8'd0);
        checkOutput("c6_err_crc_en", 8'(CRC_EN), 8'd0);
        checkOutput("c6_err_f_crc_d", 8'(F_CRC_D), 8'd1);
        checkOutput("c6_err_f_ack_d", 8'(F_ACK_D), 8'd1);
        checkOutput("c6_err_f_eof", 8'(F_EOF), 8'd1);
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("c6_rec10_field", 8'(FIELD), FLD_ERROR);
        checkOutput("c6_rec10_cnt", 8'(BIT_CNT), 8'd10);
        applyStimulus(1'b0, 1'b0);
        checkOutput("c6_dom_cnt", 8'(BIT_CNT), 8'd0);
        checkOutput("c6_dom_field", 8'(FIELD), FLD_ERROR);
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("c6_rec10b_field", 8'(FIELD), FLD_ERROR);
        applyStimulus(1'b1, 1'b0);
        checkOutput("c6_recovered_field", 8'(FIELD), FLD_IDLE);
        checkOutput("c6_recovered_cnt", 8'(BIT_CNT), 8'd0);
        checkOutput("c6_dlc_held", 8'(DLC), 8'd1);
        pulseErr();
        checkOutput("c6_err_in_idle", 8'(FIELD), FLD_IDLE);

        $display("[TB] case 6b: ERR and SP in the same cycle");
        buildFrame(1'b0, 29'h123, 1'b0, 4'd1, 8, 64'hA5);
        runTo(3);
        @(negedge clk);
        SP  = 1'b1;
        RX  = frameBits[4];
        ERR = 1'b1;
        @(posedge clk);
        #1;
        SP  = 1'b0;
        ERR = 1'b0;
        checkOutput("c6b_err_prio_field", 8'(FIELD), FLD_ERROR);
        checkOutput("c6b_err_prio_cnt", 8'(BIT_CNT), 8'd0);
        repeat (11) applyStimulus(1'b1, 1'b0);
        checkOutput("c6b_recovered", 8'(FIELD), FLD_IDLE);

        $display("[TB] case 6c: asynchronous reset in CRC");
        buildFrame(1'b0, 29'h123, 1'b0, 4'd1, 8, 64'hA5);
        crcDel = 42;
        lastCrc = 26;
        runTo(30);
        checkOutput("c6c_crc_field", 8'(FIELD), FLD_CRC);
        checkOutput("c6c_crc_cnt", 8'(BIT_CNT), 8'd4);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("async");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("c6c_after_reset", 8'(FIELD), FLD_IDLE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
